sat_pred_table: RTL



---
 rtl/sat_pred_table_if.sv | 27 ++
 rtl/sat_pred_table.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sat_pred_table_if.sv
// Lookup/update/control bundle for the saturating-counter prediction table.
// Width parameters must match the table instance that uses this interface.
interface sat_pred_table_if #(
    parameter int IDX_W = 7,
    parameter int CNT_W = 2
);
    logic             flush;
    logic             ready;
    logic             lk_valid;
    logic [IDX_W-1:0] lk_idx;
    logic             pred_valid;
    logic [CNT_W-1:0] pred_cnt;
    logic             pred_taken;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;

    modport master (
        output flush, lk_valid, lk_idx, upd_valid, upd_idx, upd_taken,
        input  ready, pred_valid, pred_cnt, pred_taken
    );

    modport slave (
        input  flush, lk_valid, lk_idx, upd_valid, upd_idx, upd_taken,
        output ready, pred_valid, pred_cnt, pred_taken
    );
endinterface

// File: rtl/sat_pred_table.sv
// Branch-prediction table of saturating counters with a self-initialising sweep,
// a 1-cycle lookup port and a 2-stage read-modify-write update pipeline.
module sat_pred_table #(
    parameter int IDX_W    = 7,
    parameter int CNT_W    = 2,
    parameter int INIT_VAL = 1
) (
    input  logic            clk,
    input  logic            reset,
    sat_pred_table_if.slave tbl
);
    localparam int               DEPTH      = 2 ** IDX_W;
    localparam logic [CNT_W-1:0] LP_INIT    = CNT_W'(INIT_VAL);
    localparam logic [CNT_W-1:0] LP_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] LP_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] LP_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] LP_LAST    = {IDX_W{1'b1}};
    localparam logic [IDX_W-1:0] LP_IDX_0   = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0] LP_IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    function automatic logic [CNT_W-1:0] sat_next(input logic [CNT_W-1:0] old,
                                                   input logic taken);
        logic [CNT_W-1:0] res;
        if (taken) begin
            if (old == LP_MAX) res = old;
            else               res = old + LP_ONE;
        end else begin
            if (old == LP_ZERO) res = old;
            else                res = old - LP_ONE;
        end
        return res;
    endfunction

    state_t           r_state;
    logic [IDX_W-1:0] r_ptr;
    logic             r_ready;
    logic             r_pred_valid;
    logic [CNT_W-1:0] r_pred_cnt;
    logic             r_pred_taken;
    logic             r_s1_valid;
    logic [IDX_W-1:0] r_s1_idx;
    logic             r_s1_taken;
    logic [CNT_W-1:0] r_s1_old;
    logic [CNT_W-1:0] r_mem [DEPTH];

    logic             w_run;
    logic             w_s2_we;
    logic [CNT_W-1:0] w_s2_cnt;
    logic             w_lk_acc;
    logic             w_upd_acc;
    logic [CNT_W-1:0] w_lk_cnt;
    logic [CNT_W-1:0] w_upd_old;
    logic             w_mem_we;
    logic [IDX_W-1:0] w_mem_addr;
    logic [CNT_W-1:0] w_mem_data;

    // Request acceptance, S2 write-back value and the bypass/forwarding muxes
    always_comb begin
        w_run     = (r_state == ST_RUN);
        w_s2_we   = w_run && r_s1_valid && !tbl.flush;
        w_s2_cnt  = sat_next(r_s1_old, r_s1_taken);
        w_lk_acc  = w_run && tbl.lk_valid;
        w_upd_acc = w_run && tbl.upd_valid && !tbl.flush;
        if (w_s2_we && (r_s1_idx == tbl.lk_idx)) begin
            w_lk_cnt = w_s2_cnt;
        end else begin
            w_lk_cnt = r_mem[tbl.lk_idx];
        end
        if (w_s2_we && (r_s1_idx == tbl.upd_idx)) begin
            w_upd_old = w_s2_cnt;
        end else begin
            w_upd_old = r_mem[tbl.upd_idx];
        end
    end

    // Single write port: the init sweep owns it outside RUN, the update pipeline inside
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = r_s1_idx;
        w_mem_data = w_s2_cnt;
        if (!w_run) begin
            w_mem_we   = 1'b1;
            w_mem_addr = r_ptr;
            w_mem_data = LP_INIT;
        end else if (w_s2_we) begin
            w_mem_we   = 1'b1;
        end else begin
            w_mem_we   = 1'b0;
        end
    end

    // Counter storage, deliberately without reset; the sweep initialises it
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Init-sweep / run state machine with registered ready
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_ptr   <= LP_IDX_0;
            r_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_ready <= 1'b0;
                    if (tbl.flush) begin
                        r_ptr <= LP_IDX_0;
                    end else if (r_ptr == LP_LAST) begin
                        r_state <= ST_RUN;
                        r_ptr   <= LP_IDX_0;
                        r_ready <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + LP_IDX_ONE;
                    end
                end
                ST_RUN: begin
                    if (tbl.flush) begin
                        r_state <= ST_INIT;
                        r_ptr   <= LP_IDX_0;
                        r_ready <= 1'b0;
                    end else begin
                        r_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_ptr   <= LP_IDX_0;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Lookup result register and S1 capture of the update pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pred_valid <= 1'b0;
            r_pred_cnt   <= LP_ZERO;
            r_pred_taken <= 1'b0;
            r_s1_valid   <= 1'b0;
            r_s1_idx     <= LP_IDX_0;
            r_s1_taken   <= 1'b0;
            r_s1_old     <= LP_ZERO;
        end else begin
            r_pred_valid <= w_lk_acc;
            if (w_lk_acc) begin
                r_pred_cnt   <= w_lk_cnt;
                r_pred_taken <= w_lk_cnt[CNT_W-1];
            end
            r_s1_valid <= w_upd_acc;
            if (w_upd_acc) begin
                r_s1_idx   <= tbl.upd_idx;
                r_s1_taken <= tbl.upd_taken;
                r_s1_old   <= w_upd_old;
            end
        end
    end

    assign tbl.ready      = r_ready;
    assign tbl.pred_valid = r_pred_valid;
    assign tbl.pred_cnt   = r_pred_cnt;
    assign tbl.pred_taken = r_pred_taken;
endmodule
